// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, fixed 33-edge latency for every operation.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] out,
  output logic [1:0]  flags
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [31:0] out_q, out_d;
  logic [1:0]  flags_q, flags_d;

  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] div_top, div_diff;
  logic        div_ge;
  logic [63:0] step_acc, prod_fix;
  logic [31:0] quo_fix, rem_fix, result;
  logic        unused_diff_msb;

  // Operand capture: which operands are signed, and their magnitudes.
  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = a_sgn && a[31];
    b_neg = b_sgn && b[31];
    a_mag = a_neg ? (~a + 32'd1) : a;
    b_mag = b_neg ? (~b + 32'd1) : b;
  end

  // One radix-2 step. Divide keeps {remainder, dividend/quotient} in acc_q;
  // the shifted partial remainder needs 33 bits before the trial subtract.
  always_comb begin
    div_top  = acc_q[63:31];
    div_diff = div_top - {1'b0, mcand_q[31:0]};
    div_ge   = (div_top >= {1'b0, mcand_q[31:0]});
    if (op_q[2]) begin
      step_acc = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                        : {div_top[31:0],  acc_q[30:0], 1'b0};
    end else begin
      step_acc = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    end
  end
  assign unused_diff_msb = div_diff[32];

  // Final sign fix-up and special-case selection, applied to the last step.
  always_comb begin
    prod_fix = neg_q ? (~step_acc + 64'd1) : step_acc;
    quo_fix  = neg_q ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
    rem_fix  = neg_rem_q ? (~step_acc[63:32] + 32'd1) : step_acc[63:32];
    case (op_q)
      OP_MUL:                         result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   result = prod_fix[63:32];
      OP_DIV, OP_DIVU:                result = dz_q ? 32'hFFFF_FFFF : quo_fix;
      default:                        result = dz_q ? a_raw_q : rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    a_raw_d   = a_raw_q;
    out_d     = out_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = 5'd0;
          op_d      = op;
          a_raw_d   = a;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[2] && (b == 32'd0);
          ovf_d     = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
          acc_d     = op[2] ? {32'd0, a_mag} : 64'd0;
          mcand_d   = {32'd0, op[2] ? b_mag : a_mag};
          mplier_d  = b_mag;
        end
      end
      CALC: begin
        acc_d    = step_acc;
        mcand_d  = op_q[2] ? mcand_q : {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          out_d   = result;
          flags_d = {ovf_q, dz_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      a_raw_q   <= 32'd0;
      out_q     <= 32'd0;
      flags_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      a_raw_q   <= a_raw_d;
      out_q     <= out_d;
      flags_q   <= flags_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = (state_q == DONE);
  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, randomized ops against an
// arithmetic reference model, plus start-while-busy and mid-op reset sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_s;
  logic [31:0] a_s, b_s;
  logic        busy, valid;
  logic [31:0] out_s;
  logic [1:0]  flags_s;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_s), .a(a_s), .b(b_s),
    .busy(busy), .valid(valid), .out(out_s), .flags(flags_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic [1:0]  exp_flags;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [1:0] f);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    int          sa32, sb32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa32 = $signed(a);
    sb32 = $signed(b);
    f = 2'b00;
    r = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      default: begin
        if (b == 32'd0) begin
          f = 2'b01;
          r = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          f = 2'b10;
          r = op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          case (op)
            3'd4:    r = sa32 / sb32;
            3'd5:    r = a / b;
            3'd6:    r = sa32 % sb32;
            default: r = a % b;
          endcase
        end
      end
    endcase
  endtask

  // Issue one op in the current cycle (caller sits just after an edge) and wait
  // for valid. Operands are scrambled after capture; an optional ignored start
  // with different operands is injected at CALC cycle inj.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] r, output logic [1:0] f,
                        output int lat, output int busy_cycles);
    op_s = op; a_s = a; b_s = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    busy_cycles = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      a_s = $urandom; b_s = $urandom; op_s = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      start = 1'b0;
      if (n == inj) begin
        start = 1'b1;
        op_s = op ^ 3'b101;
        a_s = ~a;
        b_s = b + 32'd3;
      end
      if (busy) busy_cycles++;
      if (valid) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    r = out_s;
    f = flags_s;
    if (lat < 0) chk("valid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'd0, valid}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("out_held", out_s, r);
    $display("op=%0d a=%h b=%h out=%h flags=%b lat=%0d busy=%0d", op, a, b, r, f, lat, busy_cycles);
  endtask

  initial begin
    logic [31:0] r, er;
    logic [1:0]  f, ef;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          lat, bc, vcount;

    vecs[0]  = '{3'd0, 32'd7,          32'd6,          32'h0000_002A, 2'b00};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 2'b00};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 2'b00};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 2'b00};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 2'b00};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 2'b00};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'h0000_000E, 2'b00};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'h0000_0002, 2'b00};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 2'b01};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,          32'h0000_0005, 2'b01};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 2'b10};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 2'b10};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 2'b01};
    vecs[13] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 2'b00};

    rst_n = 1'b0; start = 1'b0; op_s = 3'd0; a_s = 32'd0; b_s = 32'd0;
    #1;
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_out",   out_s,          32'd0);
    chk("reset_flags", {30'd0, flags_s}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; back-to-back issue exercises the one-op-per-34-cycles path.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, r, f, lat, bc);
      chk($sformatf("vec%0d_out", i), r, vecs[i].exp_out);
      chk($sformatf("vec%0d_flags", i), {30'd0, f}, {30'd0, vecs[i].exp_flags});
      chk($sformatf("vec%0d_latency", i), lat, 32'd32);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 32'd33);
    end

    // Start while busy must not disturb the in-flight op.
    run_op(3'd5, 32'd1000, 32'd33, 10, r, f, lat, bc);
    chk("ignored_start_out", r, 32'd30);
    chk("ignored_start_latency", lat, 32'd32);
    run_op(3'd0, 32'd3, 32'd4, -1, r, f, lat, bc);
    chk("after_done_start_out", r, 32'd12);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model(rop, ra, rb, er, ef);
      run_op(rop, ra, rb, -1, r, f, lat, bc);
      chk($sformatf("rand%0d_out", i), r, er);
      chk($sformatf("rand%0d_flags", i), {30'd0, f}, {30'd0, ef});
      chk($sformatf("rand%0d_latency", i), lat, 32'd32);
    end

    // Reset in the middle of CALC aborts the op.
    run_op(3'd0, 32'h1234, 32'h10, -1, r, f, lat, bc);
    chk("pre_reset_out", r, 32'h0001_2340);
    op_s = 3'd0; a_s = 32'd9; b_s = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("midreset_busy",  {31'd0, busy},  32'd0);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_out",   out_s,          32'd0);
    chk("midreset_flags", {30'd0, flags_s}, 32'd0);
    @(posedge clk); #1;
    chk("start_in_reset_ignored", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    vcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid || busy) vcount++;
    end
    chk("no_valid_after_abort", vcount, 32'd0);
    run_op(3'd0, 32'd3, 32'd5, -1, r, f, lat, bc);
    chk("post_reset_mul_out", r, 32'h0000_000F);
    chk("post_reset_mul_latency", lat, 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
